inst_fetch_unit: RTL and testbench

Instruction fetch stage for the multi-cycle CPU. It consumes the fetch address driven by the program counter and runs a req/ack read on the instruction memory bus. It requests a pipeline stall until the instruction word returns, then loads the IF/ID pipeline register. It sits between the program counter, the stall controller and the ID stage.

---
 rtl/inst_fetch_unit.sv | 112 +++++++++++
 tb/tb_inst_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch_unit: req/ack instruction fetch with stall request and IF/ID.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module inst_fetch_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc_i,
  input  logic [5:0]  stall,
  input  logic        flush_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ack_i,
  input  logic [31:0] inst_rdata_i,
  output logic        stallreq_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_buf;
  logic        r_discard;
  logic        w_launch;
  logic        w_done;
  logic        w_deliver;
  logic        w_unused_stall;

  // Only the IF and ID freeze bits matter to this stage.
  assign w_unused_stall = ^{stall[5:3], stall[0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!flush_i) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (inst_ack_i) w_state_nxt = (r_discard || flush_i) ? S_IDLE : S_READY;
      end
      S_READY: begin
        if (flush_i || !stall[1]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = (r_state != S_READY);
    w_launch   = (r_state == S_IDLE) && !flush_i;
    w_done     = (r_state == S_BUSY) && inst_ack_i;
    w_deliver  = (r_state == S_READY) && !stall[1] && !flush_i;
  end

  // The bus transaction always runs to its ack; a flush only marks the word for discard.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_req_o  <= 1'b0;
      inst_addr_o <= 32'd0;
      r_addr      <= 32'd0;
      r_buf       <= 32'd0;
      r_discard   <= 1'b0;
    end else begin
      if (w_launch) begin
        r_addr      <= pc_i;
        inst_addr_o <= pc_i;
        inst_req_o  <= 1'b1;
      end
      if (w_done) begin
        inst_req_o <= 1'b0;
        r_buf      <= inst_rdata_i;
        r_discard  <= 1'b0;
      end else if ((r_state == S_BUSY) && flush_i) begin
        r_discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush_i) begin
      if_valid_o <= 1'b0;
      if_inst_o  <= 32'd0;
      if_pc_o    <= 32'd0;
    end else if (w_deliver) begin
      if_valid_o <= 1'b1;
      if_inst_o  <= r_buf;
      if_pc_o    <= r_addr;
    end else if (!stall[1] || !stall[2]) begin
      if_valid_o <= 1'b0;
      if_inst_o  <= 32'd0;
      if_pc_o    <= 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_fetch_unit: directed + randomized fetch scenarios vs. IF/ID model.|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pc_i;
  logic [5:0]  stall;
  logic        flush_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i;
  logic [31:0] inst_rdata_i;
  logic        stallreq_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  int checks = 0;
  int failures = 0;

  // Expected IF/ID contents and the instruction currently held by the unit.
  logic        e_valid;
  logic [31:0] e_pc;
  logic [31:0] e_inst;
  logic [31:0] m_pc;
  logic [31:0] m_data;
  bit          g_quiet;

  inst_fetch_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .pc_i         (pc_i),
    .stall        (stall),
    .flush_i      (flush_i),
    .inst_req_o   (inst_req_o),
    .inst_addr_o  (inst_addr_o),
    .inst_ack_i   (inst_ack_i),
    .inst_rdata_i (inst_rdata_i),
    .stallreq_o   (stallreq_o),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o),
    .if_valid_o   (if_valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies the IF/ID update rules for this edge, then advances one cycle.
  task automatic clk_edge(input bit in_ready);
    if (!resetn || flush_i) begin
      e_valid = 1'b0; e_pc = 32'd0; e_inst = 32'd0;
    end else if (!stall[1] && in_ready) begin
      e_valid = 1'b1; e_pc = m_pc; e_inst = m_data;
    end else if (!stall[1] || !stall[2]) begin
      e_valid = 1'b0; e_pc = 32'd0; e_inst = 32'd0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag);
    chk({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, e_valid});
    chk({tag, ".pc"}, if_pc_o, e_pc);
    chk({tag, ".inst"}, if_inst_o, e_inst);
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr, input logic sreq);
    chk({tag, ".req"}, {31'd0, inst_req_o}, {31'd0, req});
    chk({tag, ".addr"}, inst_addr_o, addr);
    chk({tag, ".stallreq"}, {31'd0, stallreq_o}, {31'd0, sreq});
  endtask

  function automatic logic [5:0] rnd_stall();
    return g_quiet ? 6'd0 : 6'($urandom);
  endfunction

  // Full fetch starting from IDLE: launch, wait states, ack, READY hold, delivery.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                          input int waits, input int hold, input bit keep);
    logic [5:0] s;
    pc_i = pc; flush_i = 1'b0; inst_ack_i = 1'b0; stall = rnd_stall();
    clk_edge(1'b0);
    chk_bus("launch", 1'b1, pc, 1'b1);
    chk_ifid("launch");
    for (int w = 0; w < waits; w++) begin
      if (!g_quiet) pc_i = $urandom;
      stall = rnd_stall();
      clk_edge(1'b0);
      chk_bus("wait", 1'b1, pc, 1'b1);
      chk_ifid("wait");
    end
    m_pc = pc; m_data = data;
    inst_ack_i = 1'b1; inst_rdata_i = data; stall = rnd_stall();
    clk_edge(1'b0);
    inst_ack_i = 1'b0; inst_rdata_i = $urandom;
    chk_bus("ack", 1'b0, pc, 1'b0);
    chk_ifid("ack");
    for (int h = 0; h < hold; h++) begin
      s = rnd_stall(); s[1] = 1'b1; s[2] = keep; stall = s;
      clk_edge(1'b1);
      chk_bus("hold", 1'b0, pc, 1'b0);
      chk_ifid("hold");
    end
    s = rnd_stall(); s[1] = 1'b0; stall = s;
    clk_edge(1'b1);
    pc_i = pc + 32'd4;
    chk_bus("deliver", 1'b0, pc, 1'b1);
    chk_ifid("deliver");
    chk("deliver.valid_hi", {31'd0, if_valid_o}, 32'd1);
  endtask

  initial begin
    logic [31:0] p;
    g_quiet = 1'b1;
    e_valid = 1'b0; e_pc = 32'd0; e_inst = 32'd0; m_pc = 32'd0; m_data = 32'd0;
    resetn = 1'b0; pc_i = 32'hBFC0_0000; stall = 6'd0; flush_i = 1'b0;
    inst_ack_i = 1'b0; inst_rdata_i = 32'd0;
    clk_edge(1'b0);
    clk_edge(1'b0);
    chk_bus("reset", 1'b0, 32'd0, 1'b1);
    chk_ifid("reset");
    resetn = 1'b1;

    // Zero-wait fetch of the reset vector, then four wait states.
    do_fetch(32'hBFC0_0000, 32'h3C01_1234, 0, 0, 1'b0);
    do_fetch(32'hBFC0_0004, 32'h2402_0005, 4, 0, 1'b0);

    // Flush in the 2nd BUSY cycle, ack two cycles later.
    pc_i = 32'h8000_0100;
    clk_edge(1'b0);
    chk_bus("fl.launch", 1'b1, 32'h8000_0100, 1'b1);
    clk_edge(1'b0);
    flush_i = 1'b1;
    clk_edge(1'b0);
    flush_i = 1'b0;
    chk_bus("fl.busy", 1'b1, 32'h8000_0100, 1'b1);
    chk_ifid("fl.busy");
    clk_edge(1'b0);
    inst_ack_i = 1'b1; inst_rdata_i = 32'hDEAD_BEEF;
    clk_edge(1'b0);
    inst_ack_i = 1'b0;
    chk_bus("fl.drop", 1'b0, 32'h8000_0100, 1'b1);
    chk_ifid("fl.drop");
    pc_i = 32'h8000_0200;
    clk_edge(1'b0);
    chk("fl.no_beef", {31'd0, (if_valid_o && if_inst_o == 32'hDEAD_BEEF)}, 32'd0);
    chk_bus("fl.newpc", 1'b1, 32'h8000_0200, 1'b1);
    m_pc = 32'h8000_0200; m_data = 32'h0000_0011;
    inst_ack_i = 1'b1; inst_rdata_i = m_data;
    clk_edge(1'b0);
    inst_ack_i = 1'b0;
    clk_edge(1'b1);
    chk_ifid("fl.next_deliver");

    // READY hold with ID frozen, then a bubble with ID running.
    do_fetch(32'h0040_0000, 32'h8FA4_0000, 1, 3, 1'b1);
    do_fetch(32'h0040_0004, 32'h27BD_FFF0, 0, 1, 1'b0);
    do_fetch(32'h0040_0008, 32'hAFBF_0010, 2, 2, 1'b1);

    // Flush in IDLE, flush with ack, flush in READY.
    flush_i = 1'b1;
    clk_edge(1'b0);
    chk_bus("fl_idle", 1'b0, 32'h0040_0008, 1'b1);
    chk_ifid("fl_idle");
    flush_i = 1'b0; pc_i = 32'h0040_0100;
    clk_edge(1'b0);
    inst_ack_i = 1'b1; flush_i = 1'b1; inst_rdata_i = 32'h1111_2222;
    clk_edge(1'b0);
    inst_ack_i = 1'b0; flush_i = 1'b0;
    chk_bus("fl_ack", 1'b0, 32'h0040_0100, 1'b1);
    chk_ifid("fl_ack");
    pc_i = 32'h0040_0200;
    clk_edge(1'b0);
    inst_ack_i = 1'b1; inst_rdata_i = 32'h3333_4444;
    clk_edge(1'b0);
    inst_ack_i = 1'b0;
    chk("fl_rdy.stallreq", {31'd0, stallreq_o}, 32'd0);
    flush_i = 1'b1; stall = 6'd0;
    clk_edge(1'b1);
    flush_i = 1'b0;
    chk_bus("fl_rdy", 1'b0, 32'h0040_0200, 1'b1);
    chk_ifid("fl_rdy");

    // Reset mid-transaction, then a stray ack while IDLE.
    pc_i = 32'h0040_0300;
    clk_edge(1'b0);
    chk_bus("rm.busy", 1'b1, 32'h0040_0300, 1'b1);
    resetn = 1'b0;
    clk_edge(1'b0);
    chk_bus("rm.reset", 1'b0, 32'd0, 1'b1);
    chk_ifid("rm.reset");
    resetn = 1'b1; inst_ack_i = 1'b1; inst_rdata_i = 32'h5555_6666; pc_i = 32'h0040_0400;
    clk_edge(1'b0);
    inst_ack_i = 1'b0;
    chk_bus("rm.stray", 1'b1, 32'h0040_0400, 1'b1);
    chk_ifid("rm.stray");
    clk_edge(1'b0);
    chk_bus("rm.still_busy", 1'b1, 32'h0040_0400, 1'b1);
    chk_ifid("rm.still_busy");
    m_pc = 32'h0040_0400; m_data = 32'h7777_8888;
    inst_ack_i = 1'b1; inst_rdata_i = m_data;
    clk_edge(1'b0);
    inst_ack_i = 1'b0;
    clk_edge(1'b1);
    chk_ifid("rm.deliver");

    // Randomized fetches with random stall vectors, wait states and holds.
    g_quiet = 1'b0;
    for (int i = 0; i < 24; i++) begin
      p = {$urandom} & 32'hFFFF_FFFC;
      do_fetch(p, $urandom, $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
